// File: rtl/vga_board_renderer.sv
// 640x480@60 VGA renderer for the player and PC 5x5 boards, with a two-stage colour pipeline.
// Optional macro HIDE_PC_SHIPS_EN draws PC ship cells (codes 1-5) as water.
module vga_board_renderer #(
  parameter int H_ORIGIN_PLAYER = 0,
  parameter int H_ORIGIN_PC     = 320,
  parameter int V_ORIGIN        = 80
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0][4:0][3:0] matriz_player_final,
  input  logic [4:0][4:0][3:0] matriz_pc_final,
  output logic                 vga_clk,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 blank_n,
  output logic                 sync_n,
  output logic [7:0]           red,
  output logic [7:0]           green,
  output logic [7:0]           blue,
  output logic                 frame_start
);

  localparam logic [9:0] H_LAST     = 10'd799;
  localparam logic [9:0] V_LAST     = 10'd524;
  localparam logic [9:0] H_VISIBLE  = 10'd640;
  localparam logic [9:0] V_VISIBLE  = 10'd480;
  localparam logic [9:0] HS_FIRST   = 10'd656;
  localparam logic [9:0] HS_LAST    = 10'd751;
  localparam logic [9:0] VS_FIRST   = 10'd490;
  localparam logic [9:0] VS_LAST    = 10'd491;
  localparam logic [9:0] BOARD_SPAN = 10'd320;
  localparam logic [9:0] ORG_PLAYER = 10'(H_ORIGIN_PLAYER);
  localparam logic [9:0] ORG_PC     = 10'(H_ORIGIN_PC);
  localparam logic [9:0] ORG_V      = 10'(V_ORIGIN);

  localparam logic [23:0] RGB_BLACK  = 24'h000000;
  localparam logic [23:0] RGB_WATER  = 24'h0000FF;
  localparam logic [23:0] RGB_SHIP   = 24'h808080;
  localparam logic [23:0] RGB_MISS   = 24'hFFFFFF;
  localparam logic [23:0] RGB_HIT    = 24'hFF0000;
  localparam logic [23:0] RGB_SUNK   = 24'h800000;
  localparam logic [23:0] RGB_CURSOR = 24'hFFFF00;
  localparam logic [23:0] RGB_ERROR  = 24'hFF00FF;

  logic                 tick_q;
  logic                 tick;
  logic [9:0]           hCnt_q, hCnt_d;
  logic [9:0]           vCnt_q, vCnt_d;
  logic                 frameEnd;
  logic                 frameStart_q;
  logic [4:0][4:0][3:0] shPlayer_q;
  logic [4:0][4:0][3:0] shPc_q;

  logic [9:0] lxPlayer, lxPc, ly;
  logic [8:0] lx;
  logic       inRows;
  logic       s1Vis_d, s1Player_d, s1Pc_d, s1Grid_d, s1Hs_d, s1Vs_d;
  logic [2:0] s1Row_d, s1Col_d;
  logic       s1Vis_q, s1Player_q, s1Pc_q, s1Grid_q, s1Hs_q, s1Vs_q;
  logic [2:0] s1Row_q, s1Col_q;

  logic [3:0]  cellCode;
  logic        hiddenShip;
  logic [23:0] rgb_d, rgb_q;
  logic        hsync_q, vsync_q, blank_q;

  assign tick     = ~tick_q;
  assign frameEnd = (hCnt_q == H_LAST) && (vCnt_q == V_LAST);
  assign hCnt_d   = (hCnt_q == H_LAST) ? 10'd0 : hCnt_q + 10'd1;
  assign vCnt_d   = (hCnt_q != H_LAST) ? vCnt_q :
                    (vCnt_q == V_LAST) ? 10'd0 : vCnt_q + 10'd1;

  // Shadows reload only at the last pixel of the frame so a frame never mixes two boards.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q       <= 1'b0;
      hCnt_q       <= '0;
      vCnt_q       <= '0;
      frameStart_q <= 1'b0;
      shPlayer_q   <= '0;
      shPc_q       <= '0;
    end else begin
      tick_q       <= ~tick_q;
      frameStart_q <= tick && frameEnd;
      if (tick) begin
        hCnt_q <= hCnt_d;
        vCnt_q <= vCnt_d;
        if (frameEnd) begin
          shPlayer_q <= matriz_player_final;
          shPc_q     <= matriz_pc_final;
        end
      end
    end
  end

  // Unsigned wrap-around makes a single "< 320" test cover both edges of each board.
  always_comb begin
    lxPlayer   = hCnt_q - ORG_PLAYER;
    lxPc       = hCnt_q - ORG_PC;
    ly         = vCnt_q - ORG_V;
    inRows     = ly < BOARD_SPAN;
    s1Player_d = inRows && (lxPlayer < BOARD_SPAN);
    s1Pc_d     = inRows && !s1Player_d && (lxPc < BOARD_SPAN);
    lx         = s1Player_d ? lxPlayer[8:0] : lxPc[8:0];
    s1Grid_d   = (lx[5:0] == 6'd0) || (lx[5:0] == 6'd63) ||
                 (ly[5:0] == 6'd0) || (ly[5:0] == 6'd63);
    s1Col_d    = (s1Player_d || s1Pc_d) ? lx[8:6] : 3'd0;
    s1Row_d    = (s1Player_d || s1Pc_d) ? ly[8:6] : 3'd0;
    s1Vis_d    = (hCnt_q < H_VISIBLE) && (vCnt_q < V_VISIBLE);
    s1Hs_d     = !((hCnt_q >= HS_FIRST) && (hCnt_q <= HS_LAST));
    s1Vs_d     = !((vCnt_q >= VS_FIRST) && (vCnt_q <= VS_LAST));
  end

  always_comb begin
    cellCode   = s1Pc_q ? shPc_q[s1Row_q][s1Col_q] : shPlayer_q[s1Row_q][s1Col_q];
    hiddenShip = 1'b0;
`ifdef HIDE_PC_SHIPS_EN
    hiddenShip = s1Pc_q;
`endif
    rgb_d = RGB_BLACK;
    if (s1Vis_q && (s1Player_q || s1Pc_q) && !s1Grid_q) begin
      case (cellCode)
        4'd0:                         rgb_d = RGB_WATER;
        4'd1, 4'd2, 4'd3, 4'd4, 4'd5: rgb_d = hiddenShip ? RGB_WATER : RGB_SHIP;
        4'd6:                         rgb_d = RGB_MISS;
        4'd7:                         rgb_d = RGB_HIT;
        4'd8:                         rgb_d = RGB_SUNK;
        4'd9:                         rgb_d = RGB_CURSOR;
        default:                      rgb_d = RGB_ERROR;
      endcase
    end
  end

  // Sync levels idle high through reset so the DAC never sees a spurious sync pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1Vis_q    <= 1'b0;
      s1Player_q <= 1'b0;
      s1Pc_q     <= 1'b0;
      s1Grid_q   <= 1'b0;
      s1Row_q    <= '0;
      s1Col_q    <= '0;
      s1Hs_q     <= 1'b1;
      s1Vs_q     <= 1'b1;
      rgb_q      <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      blank_q    <= 1'b0;
    end else if (tick) begin
      s1Vis_q    <= s1Vis_d;
      s1Player_q <= s1Player_d;
      s1Pc_q     <= s1Pc_d;
      s1Grid_q   <= s1Grid_d;
      s1Row_q    <= s1Row_d;
      s1Col_q    <= s1Col_d;
      s1Hs_q     <= s1Hs_d;
      s1Vs_q     <= s1Vs_d;
      rgb_q      <= rgb_d;
      hsync_q    <= s1Hs_q;
      vsync_q    <= s1Vs_q;
      blank_q    <= s1Vis_q;
    end
  end

  assign vga_clk     = tick_q;
  assign frame_start = frameStart_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank_n     = blank_q;
  assign sync_n      = 1'b0;
  assign red         = rgb_q[23:16];
  assign green       = rgb_q[15:8];
  assign blue        = rgb_q[7:0];

endmodule

// File: tb/tb_vga_board_renderer.sv
// Randomised bench for vga_board_renderer: a raster-position reference model predicts every output on every clk.
// Counter jumps (forcing the next-count nets) keep whole-frame behaviour reachable in a short run.
module tb_vga_board_renderer;

  localparam int FRAME_PIXELS = 800 * 525;
  localparam int HP  = 0;
  localparam int HPC = 320;
  localparam int VO  = 80;
`ifdef HIDE_PC_SHIPS_EN
  localparam bit HIDE_PC = 1'b1;
`else
  localparam bit HIDE_PC = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [4:0][4:0][3:0] matPlayer, matPc;
  logic                 vgaClk, hsync, vsync, blankN, syncN, frameStart;
  logic [7:0]           red, green, blue;

  always #10 clk = ~clk;

  vga_board_renderer #(
    .H_ORIGIN_PLAYER(HP),
    .H_ORIGIN_PC    (HPC),
    .V_ORIGIN       (VO)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .matriz_player_final(matPlayer),
    .matriz_pc_final    (matPc),
    .vga_clk            (vgaClk),
    .hsync              (hsync),
    .vsync              (vsync),
    .blank_n            (blankN),
    .sync_n             (syncN),
    .red                (red),
    .green              (green),
    .blue               (blue),
    .frame_start        (frameStart)
  );

  int nChecks = 0;
  int nFails  = 0;

  bit                   mTickQ;
  int                   mPos;
  int                   mS1Pos;
  logic [23:0]          expRgb;
  logic                 expHs, expVs, expBlank, expFs;
  logic [4:0][4:0][3:0] mShPlayer, mShPc;
  bit                   jumpReq = 1'b0;
  int                   jumpPos;
  logic [9:0]           jumpH, jumpV;

  function automatic logic [23:0] codeColour(input logic [3:0] code, input bit onPc);
    if (code == 4'd0) return 24'h0000FF;
    if (code <= 4'd5) return (onPc && HIDE_PC) ? 24'h0000FF : 24'h808080;
    case (code)
      4'd6:    return 24'hFFFFFF;
      4'd7:    return 24'hFF0000;
      4'd8:    return 24'h800000;
      4'd9:    return 24'hFFFF00;
      default: return 24'hFF00FF;
    endcase
  endfunction

  // Returns {hsync, vsync, blank_n, rgb} for raster position p using the current model shadows.
  function automatic logic [26:0] pixelModel(input int p);
    int h, v, lx, ly;
    bit onPl, onPc, vis, hs, vs;
    logic [23:0] rgb;
    h    = p % 800;
    v    = p / 800;
    hs   = !(h >= 656 && h <= 751);
    vs   = !(v == 490 || v == 491);
    vis  = (h < 640) && (v < 480);
    onPl = (h >= HP) && (h < HP + 320) && (v >= VO) && (v < VO + 320);
    onPc = !onPl && (h >= HPC) && (h < HPC + 320) && (v >= VO) && (v < VO + 320);
    rgb  = 24'h0;
    if (vis && (onPl || onPc)) begin
      lx = h - (onPl ? HP : HPC);
      ly = v - VO;
      if (!((lx % 64) == 0 || (lx % 64) == 63 || (ly % 64) == 0 || (ly % 64) == 63))
        rgb = codeColour(onPl ? mShPlayer[ly / 64][lx / 64] : mShPc[ly / 64][lx / 64], onPc);
    end
    return {hs, vs, vis, rgb};
  endfunction

  task automatic modelUpdate();
    if (rst) begin
      mTickQ    = 1'b0;
      mPos      = 0;
      mS1Pos    = -1;
      expRgb    = 24'h0;
      expHs     = 1'b1;
      expVs     = 1'b1;
      expBlank  = 1'b0;
      expFs     = 1'b0;
      mShPlayer = '0;
      mShPc     = '0;
    end else begin
      expFs = 1'b0;
      if (!mTickQ) begin
        if (mS1Pos >= 0) {expHs, expVs, expBlank, expRgb} = pixelModel(mS1Pos);
        else             {expHs, expVs, expBlank, expRgb} = {1'b1, 1'b1, 1'b0, 24'h0};
        if (mPos == FRAME_PIXELS - 1) begin
          mShPlayer = matPlayer;
          mShPc     = matPc;
          expFs     = 1'b1;
        end
        mS1Pos = mPos;
        mPos   = jumpReq ? jumpPos : (mPos + 1) % FRAME_PIXELS;
      end
      mTickQ = !mTickQ;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic stepClk();
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
    checkOutput("video", 32'({hsync, vsync, blankN, red, green, blue}),
                32'({expHs, expVs, expBlank, expRgb}));
    checkOutput("ctrl", 32'({vgaClk, frameStart, syncN}), 32'({mTickQ, expFs, 1'b0}));
  endtask

  task automatic runClocks(input int n);
    for (int i = 0; i < n; i++) stepClk();
  endtask

  // mode 0: random codes; mode 1: random plus the directed cells; mode 2: every cell a miss.
  task automatic applyStimulus(input int mode);
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        matPlayer[r][c] = (mode == 2) ? 4'd6 : 4'($urandom_range(0, 15));
        matPc[r][c]     = (mode == 2) ? 4'd6 : 4'($urandom_range(0, 15));
      end
    end
    if (mode == 1) begin
      matPlayer[0][0] = 4'd7;
      matPlayer[2][2] = 4'd2;
      matPc[4][4]     = 4'd9;
      matPc[2][2]     = 4'd2;
    end
  endtask

  task automatic jumpTo(input int h, input int v);
    if (mTickQ) stepClk();
    jumpH   = 10'(h);
    jumpV   = 10'(v);
    jumpPos = v * 800 + h;
    force dut.hCnt_d = jumpH;
    force dut.vCnt_d = jumpV;
    jumpReq = 1'b1;
    stepClk();
    release dut.hCnt_d;
    release dut.vCnt_d;
    jumpReq = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0);
    runClocks(3);
    rst = 1'b0;
    runClocks(2 * 1600);

    // First frame after reset must stay all-water whatever the inputs do.
    jumpTo(700, 79);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0);
      runClocks(1600);
    end

    // One-clk reset in the middle of line 250.
    jumpTo(0, 249);
    runClocks(1600 + 2 * $urandom_range(100, 600));
    rst = 1'b1;
    stepClk();
    rst = 1'b0;
    runClocks(2 * 1600);

    // Directed board loaded at frame end, then boundary lines of the new frame.
    applyStimulus(1);
    jumpTo(780, 524);
    runClocks(80);
    applyStimulus(0);
    jumpTo(0, 111);
    runClocks(2 * 1600);
    jumpTo(0, 238);
    runClocks(3 * 1600);
    jumpTo(0, 366);
    runClocks(3 * 1600);
    jumpTo(0, 397);
    runClocks(5 * 1600);
    jumpTo(0, 478);
    runClocks(3 * 1600);
    jumpTo(600, 489);
    runClocks(3 * 1600);

    // Inputs switch to all-miss at (100,200): invisible until the next load.
    applyStimulus(1);
    jumpTo(790, 524);
    runClocks(40);
    jumpTo(90, 200);
    runClocks(20);
    applyStimulus(2);
    runClocks(2 * 1600);
    jumpTo(790, 524);
    runClocks(40);
    jumpTo(0, 150);
    runClocks(1600);

    // A few random boards, each viewed on a random line.
    for (int f = 0; f < 3; f++) begin
      applyStimulus(0);
      jumpTo(790, 524);
      runClocks(40);
      jumpTo(0, $urandom_range(78, 402));
      runClocks(1600);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
